// File: rtl/pll_sup_pkg.sv
// Shared state encoding, parameter defaults and sizing helper for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } sup_state_t;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1000;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 100000;
  localparam int unsigned SYNC_STAGES             = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/signal_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module signal_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for and qualifies lock, then releases the PLL-domain reset;
// retries on timeout, lock loss or a forced relock request.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic       timeout_err,
  output logic [1:0] state_o
);

  localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  sup_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       loss_q, loss_d;
  logic             tmo_q, tmo_d;
  logic             pll_rst_q, sys_rst_q, ready_q;
  logic             lock_s;

  signal_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d_i(pll_locked),
    .q_o(lock_s)
  );

  always_comb begin
    state_d = state_q;
    loss_d  = loss_q;
    tmo_d   = tmo_q;
    case (state_q)
      PLL_RESET: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (force_relock) begin
          state_d = PLL_RESET;
        end else if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = PLL_RESET;
        end
      end
      STABLE: begin
        if (force_relock) begin
          state_d = PLL_RESET;
        end else if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A lock loss is counted once even when a relock request arrives together with it.
        if (!lock_s) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          state_d = PLL_RESET;
        end else if (force_relock) begin
          state_d = PLL_RESET;
        end
      end
      default: state_d = PLL_RESET;
    endcase

    // Counter restarts on every state entry; it idles in RUN where nothing uses it.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RESET;
      cnt_q     <= '0;
      loss_q    <= '0;
      tmo_q     <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loss_q    <= loss_d;
      tmo_q     <= tmo_d;
      pll_rst_q <= (state_d == PLL_RESET);
      sys_rst_q <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_q;
  assign timeout_err     = tmo_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench: instance A runs bring-up/glitch/relock/timeout/reset scenarios,
// instance B (short timings) runs the lock-loss saturation scenario.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst_a, locked_a, force_a;
  logic       pll_rst_a, sys_rst_a, ready_a, tmo_a;
  logic [7:0] loss_a;
  logic [1:0] state_a;
  logic       rst_b, locked_b, force_b;
  logic       pll_rst_b, sys_rst_b, ready_b, tmo_b;
  logic [7:0] loss_b;
  logic [1:0] state_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(16),
    .LOCK_STABLE_CYCLES(1000),
    .LOCK_TIMEOUT_CYCLES(200)
  ) dut_a (
    .refclk(clk), .rst(rst_a), .pll_locked(locked_a), .force_relock(force_a),
    .pll_rst(pll_rst_a), .sys_rst(sys_rst_a), .ready(ready_a),
    .lock_loss_count(loss_a), .timeout_err(tmo_a), .state_o(state_a)
  );

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(2),
    .LOCK_STABLE_CYCLES(2),
    .LOCK_TIMEOUT_CYCLES(50)
  ) dut_b (
    .refclk(clk), .rst(rst_b), .pll_locked(locked_b), .force_relock(force_b),
    .pll_rst(pll_rst_b), .sys_rst(sys_rst_b), .ready(ready_b),
    .lock_loss_count(loss_b), .timeout_err(tmo_b), .state_o(state_b)
  );

  // Counts negedge samples with pll_rst_a high, starting at the current negedge.
  task automatic count_pulse_a(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!pll_rst_a) break;
      n++;
      @(negedge clk);
    end
  endtask

  // Counts posedges until ready_a is seen high; -1 if it never rises within the budget.
  task automatic wait_ready_a(output int edges);
    edges = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk); #1;
      if (ready_a) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic wait_state_a(input logic [1:0] st, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (state_a == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b1; locked_a = 1'b0; force_a = 1'b0;
    rst_b = 1'b1; locked_b = 1'b0; force_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pll_rst_a, sys_rst_a, ready_a, tmo_a, state_a, loss_a} !== {4'b1100, 2'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_a: got %b required %b",
               {pll_rst_a, sys_rst_a, ready_a, tmo_a, state_a, loss_a}, {4'b1100, 2'd0, 8'd0});
    end
    checks++;
    if ({pll_rst_b, sys_rst_b, ready_b, tmo_b, state_b, loss_b} !== {4'b1100, 2'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_b: got %b required %b",
               {pll_rst_b, sys_rst_b, ready_b, tmo_b, state_b, loss_b}, {4'b1100, 2'd0, 8'd0});
    end
    $display("reset: outputs sampled under rst");
  endtask

  task automatic test_bringup;
    int n, e;
    rst_a = 1'b0;
    count_pulse_a(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL bringup_pll_rst_len: got %0d required 16", n);
    end
    repeat (34) @(negedge clk);
    locked_a = 1'b1;
    wait_ready_a(e);
    checks++;
    if (e !== 1003) begin
      errors++;
      $display("FAIL bringup_ready_latency: got %0d required 1003", e);
    end
    checks++;
    if ({sys_rst_a, pll_rst_a, state_a} !== {2'b00, 2'd3}) begin
      errors++;
      $display("FAIL bringup_run_outputs: got %b required %b", {sys_rst_a, pll_rst_a, state_a}, 4'b0011);
    end
    $display("bringup: pll_rst %0d cycles, ready after %0d edges", n, e);
  endtask

  task automatic test_glitch;
    int e;
    bit ok;
    @(negedge clk); force_a = 1'b1;
    @(negedge clk); force_a = 1'b0;
    checks++;
    if ({state_a, pll_rst_a, ready_a, loss_a} !== {2'd0, 2'b10, 8'd0}) begin
      errors++;
      $display("FAIL force_relock_run: got %b required %b", {state_a, pll_rst_a, ready_a, loss_a}, {2'd0, 2'b10, 8'd0});
    end
    wait_state_a(2'd2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL glitch_reach_stable: got state %0d required 2", state_a);
    end
    repeat (500) @(posedge clk);
    @(negedge clk); locked_a = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (state_a !== 2'd1) begin
      errors++;
      $display("FAIL glitch_back_to_wait: got %0d required 1", state_a);
    end
    locked_a = 1'b1;
    wait_ready_a(e);
    checks++;
    if (e !== 1003) begin
      errors++;
      $display("FAIL glitch_requalify: got %0d required 1003", e);
    end
    checks++;
    if (loss_a !== 8'd0) begin
      errors++;
      $display("FAIL glitch_loss_count: got %0d required 0", loss_a);
    end
    $display("glitch: requalified, ready after %0d edges, losses %0d", e, loss_a);
  endtask

  task automatic test_unlock_force;
    int n;
    @(negedge clk); locked_a = 1'b0;
    @(negedge clk);
    @(negedge clk); force_a = 1'b1;
    checks++;
    if (ready_a !== 1'b1) begin
      errors++;
      $display("FAIL unlock_ready_early: got %b required 1", ready_a);
    end
    @(posedge clk); #1;
    checks++;
    if ({ready_a, sys_rst_a, pll_rst_a, loss_a} !== {3'b011, 8'd1}) begin
      errors++;
      $display("FAIL unlock_force_outputs: got %b required %b", {ready_a, sys_rst_a, pll_rst_a, loss_a}, {3'b011, 8'd1});
    end
    @(negedge clk); force_a = 1'b0;
    count_pulse_a(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL unlock_pll_rst_len: got %0d required 16", n);
    end
    $display("unlock+force: losses %0d, pll_rst %0d cycles", loss_a, n);
  endtask

  task automatic test_timeout;
    int n;
    bit ok;
    repeat (199) @(negedge clk);
    checks++;
    if ({tmo_a, state_a} !== {1'b0, 2'd1}) begin
      errors++;
      $display("FAIL timeout_early: got %b required %b", {tmo_a, state_a}, 3'b001);
    end
    @(negedge clk);
    checks++;
    if ({tmo_a, state_a, pll_rst_a} !== {1'b1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_fire: got %b required %b", {tmo_a, state_a, pll_rst_a}, 4'b1001);
    end
    count_pulse_a(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL timeout_pll_rst_len: got %0d required 16", n);
    end
    locked_a = 1'b1;
    wait_state_a(2'd2, ok);
    checks++;
    if (!ok || tmo_a !== 1'b1 || loss_a !== 8'd1) begin
      errors++;
      $display("FAIL timeout_sticky: got state %0d tmo %b loss %0d required 2 1 1", state_a, tmo_a, loss_a);
    end
    $display("timeout: timeout_err %b, retry pulse %0d cycles", tmo_a, n);
  endtask

  task automatic test_reset_mid;
    int n;
    #2 rst_a = 1'b1;
    #1;
    checks++;
    if ({pll_rst_a, sys_rst_a, ready_a, tmo_a, state_a, loss_a} !== {4'b1100, 2'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid_async: got %b required %b",
               {pll_rst_a, sys_rst_a, ready_a, tmo_a, state_a, loss_a}, {4'b1100, 2'd0, 8'd0});
    end
    @(negedge clk); rst_a = 1'b0;
    count_pulse_a(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL reset_mid_pulse: got %0d required 16", n);
    end
    $display("reset mid-stable: outputs cleared, new pulse %0d cycles", n);
  endtask

  task automatic test_saturation;
    int exp;
    bit ok;
    @(negedge clk); rst_b = 1'b0; locked_b = 1'b1;
    for (int ev = 1; ev <= 260; ev++) begin
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (ready_b) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sat_ready_timeout: event %0d ready %b required 1", ev, ready_b);
        break;
      end
      locked_b = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (!ready_b) begin ok = 1'b1; break; end
      end
      locked_b = 1'b1;
      exp = (ev > 255) ? 255 : ev;
      checks++;
      if (!ok || loss_b !== 8'(exp)) begin
        errors++;
        $display("FAIL sat_count: event %0d got %0d required %0d", ev, loss_b, exp);
      end
      if (ev == 1 || ev == 255 || ev == 256 || ev == 260)
        $display("saturation: event %0d lock_loss_count %0d", ev, loss_b);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_unlock_force();
    test_timeout();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
